// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg
// Shared definitions for the logic_gate_pipe block: the 3-bit operation
// encoding used on in_op and carried through the pipeline.
package logic_gate_pkg;

    // All eight codes are legal; NOT_A and PASS_A ignore operand B.
    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_t;

    localparam int OP_W = 3;

endpackage

// File: rtl/logic_op_core.sv
// logic_op_core
// Purely combinational gate evaluator. Applies the selected bitwise
// operation to a/b and derives reduction flags from the final result.
// Ports:
//   op     : operation select (op_t)
//   a, b   : WIDTH-bit operands
//   y      : bitwise result
//   zero   : y == 0
//   ones   : y is all ones
//   parity : XOR-reduction of y
module logic_op_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    always_comb begin
        y = a;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_XNOR:   y = ~(a ^ b);
            OP_NOT_A:  y = ~a;
            OP_PASS_A: y = a;
            default:   y = a;
        endcase
    end

    // Flags always follow the final y, so NOT_A/PASS_A get them too.
    // For WIDTH=1 these reduce to zero=~y, ones=y, parity=y.
    assign zero   = ~|y;
    assign ones   = &y;
    assign parity = ^y;

endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe
// Two-stage pipelined bitwise gate with reduction flags and a count of
// completed results. S1 registers (op, a, b); S2 registers y and flags.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready         : upstream handshake
//   in_op, in_a, in_b         : operation select and operands
//   out_valid/out_ready       : downstream handshake
//   out_y                     : bitwise result
//   out_zero/ones/parity      : reduction flags of out_y
//   done_cnt                  : output handshakes since reset (wraps)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds valid and payload until that edge; ready never
// depends on valid of the same interface (in_ready is a function of
// pipeline occupancy and out_ready only).
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] done_cnt
);

    // Stage 1: registered request
    logic             s1_valid;
    op_t              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Stage 2: registered result
    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic             s2_zero;
    logic             s2_ones;
    logic             s2_parity;

    logic [CNT_W-1:0] cnt_q;

    // Combinational result of the S1 contents
    logic [WIDTH-1:0] core_y;
    logic             core_zero;
    logic             core_ones;
    logic             core_parity;

    logic s2_adv;
    logic in_fire;
    logic out_fire;

    // S2 can take new data when empty or being drained this edge; S1 can
    // take new data when empty or when its contents move into S2.
    assign s2_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid && out_ready;

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .y      (core_y),
        .zero   (core_zero),
        .ones   (core_ones),
        .parity (core_parity)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            // Either S1 was empty or its contents shift into S2 this edge.
            s1_valid <= in_valid;
            if (in_fire) begin
                s1_op <= op_t'(in_op);
                s1_a  <= in_a;
                s1_b  <= in_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_y      <= '0;
            s2_zero   <= 1'b0;
            s2_ones   <= 1'b0;
            s2_parity <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            // On a bubble the old payload is left in place; out_valid=0
            // marks it as meaningless.
            if (s1_valid) begin
                s2_y      <= core_y;
                s2_zero   <= core_zero;
                s2_ones   <= core_ones;
                s2_parity <= core_parity;
            end
        end
    end

    // Free-running wrap at 2^CNT_W with no saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_fire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid  = s2_valid;
    assign out_y      = s2_y;
    assign out_zero   = s2_zero;
    assign out_ones   = s2_ones;
    assign out_parity = s2_parity;
    assign done_cnt   = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe
// Self-checking bench for logic_gate_pipe. A second instance with CNT_W=2
// shares all inputs so counter wrap can be observed alongside the main one.
module tb_logic_gate_pipe;

    localparam int W  = 8;
    localparam int CW = 16;
    localparam int EW = W + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic          out_zero;
    logic          out_ones;
    logic          out_parity;
    logic [CW-1:0] done_cnt;

    logic          in_ready2;
    logic          out_valid2;
    logic [W-1:0]  out_y2;
    logic          out_zero2;
    logic          out_ones2;
    logic          out_parity2;
    logic [1:0]    done_cnt2;

    logic_gate_pipe #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
        .done_cnt(done_cnt)
    );

    logic_gate_pipe #(.WIDTH(W), .CNT_W(2)) u_dut_cnt2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid2), .out_ready(out_ready), .out_y(out_y2),
        .out_zero(out_zero2), .out_ones(out_ones2), .out_parity(out_parity2),
        .done_cnt(done_cnt2)
    );

    // ---------------- reference model ----------------
    int tests = 0;
    int fails = 0;
    logic [EW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt;

    // Truth-table level model: each result bit is looked up from the
    // gate's 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [EW-1:0] ref_result(input logic [2:0] op,
                                                 input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [3:0] tt;
        logic [W-1:0] y;
        logic z, o, p;
        case (op)
            3'd0: tt = 4'b1000; // AND
            3'd1: tt = 4'b1110; // OR
            3'd2: tt = 4'b0110; // XOR
            3'd3: tt = 4'b0111; // NAND
            3'd4: tt = 4'b0001; // NOR
            3'd5: tt = 4'b1001; // XNOR
            3'd6: tt = 4'b0011; // NOT_A
            default: tt = 4'b1100; // PASS_A
        endcase
        for (int i = 0; i < W; i++) y[i] = tt[{a[i], b[i]}];
        z = (y == '0);
        o = (y == {W{1'b1}});
        p = (($countones(y) % 2) == 1);
        return {p, o, z, y};
    endfunction

    // ---------------- scoreboard monitor ----------------
    // Looks at the handshake signals half a cycle before the edge that
    // will act on them.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if (done_cnt !== exp_cnt) begin
                fails++;
                $display("FAIL done_cnt: got %0d exp %0d", done_cnt, exp_cnt);
            end
            tests++;
            if (done_cnt2 !== exp_cnt[1:0]) begin
                fails++;
                $display("FAIL done_cnt_w2: got %0d exp %0d", done_cnt2, exp_cnt[1:0]);
            end
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got y=%h with empty queue", out_y);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    if ({out_parity, out_ones, out_zero, out_y} !== e) begin
                        fails++;
                        $display("FAIL result: got p%b o%b z%b y=%h exp p%b o%b z%b y=%h",
                                 out_parity, out_ones, out_zero, out_y,
                                 e[W+2], e[W+1], e[W], e[W-1:0]);
                    end
                end
                exp_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_result(in_op, in_a, in_b));
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic apply_reset;
        rst = 1'b1;
        exp_q.delete();
        exp_cnt = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Single transaction on an empty pipe with out_ready=1; checks the
    // 2-cycle latency and the result against the given expectations.
    task automatic send_one(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ey, input logic ez, input logic eo,
                            input logic ep, input string name);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        #2;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL %s_in_ready: got %b exp 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL %s_early_valid: got %b exp 0", name, out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_y !== ey || out_zero !== ez ||
            out_ones !== eo || out_parity !== ep) begin
            fails++;
            $display("FAIL %s: got v%b y=%h z%b o%b p%b exp v1 y=%h z%b o%b p%b", name,
                     out_valid, out_y, out_zero, out_ones, out_parity, ey, ez, eo, ep);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        #3;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_y !== '0 || out_zero !== 1'b0 ||
            out_ones !== 1'b0 || out_parity !== 1'b0 || done_cnt !== '0) begin
            fails++;
            $display("FAIL reset_state: got rdy%b v%b y=%h z%b o%b p%b cnt%0d exp rdy1 v0 y=00 z0 o0 p0 cnt0",
                     in_ready, out_valid, out_y, out_zero, out_ones, out_parity, done_cnt);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_ops;
        logic [W-1:0] ey_tab [8];
        ey_tab = '{8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'h5A, 8'hA5};
        for (int k = 0; k < 8; k++) begin
            logic [W-1:0] ey;
            ey = ey_tab[k];
            send_one(3'(k), 8'hA5, 8'h3C, ey, (ey == 8'h00), (ey == 8'hFF),
                     (($countones(ey) % 2) == 1), $sformatf("op%0d", k));
        end
    endtask

    task automatic test_flags;
        send_one(3'd0, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, "flag_zero");
        send_one(3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1, 1'b0, "flag_ones");
    endtask

    task automatic test_back_to_back;
        logic [CW-1:0] base;
        base = exp_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_op = 3'($urandom_range(0, 7));
            in_a = W'($urandom); in_b = W'($urandom);
            #2;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++; $display("FAIL b2b_in_ready[%0d]: got %b exp 1", i, in_ready);
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                tests++;
                if (out_valid !== 1'b1) begin
                    fails++; $display("FAIL b2b_out_valid[%0d]: got %b exp 1", i, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (exp_cnt !== base + 16'd6 || done_cnt !== base + 16'd6) begin
            fails++;
            $display("FAIL b2b_count: got %0d (model %0d) exp %0d", done_cnt, exp_cnt, base + 16'd6);
        end
    endtask

    task automatic test_stall;
        logic [2:0]   ops [6];
        logic [W-1:0] as_ [6];
        logic [W-1:0] bs_ [6];
        logic [EW-1:0] r0, r1;
        logic [CW-1:0] base;
        logic acc;
        int sent;
        sent = 0;
        base = exp_cnt;
        for (int i = 0; i < 6; i++) begin
            ops[i] = 3'($urandom_range(0, 7));
            as_[i] = W'($urandom); bs_[i] = W'($urandom);
        end
        r0 = ref_result(ops[0], as_[0], bs_[0]);
        r1 = ref_result(ops[1], as_[1], bs_[1]);
        for (int c = 0; c < 20; c++) begin
            out_ready = (c >= 4);
            in_valid = (sent < 6);
            if (sent < 6) begin
                in_op = ops[sent]; in_a = as_[sent]; in_b = bs_[sent];
            end
            #2;
            if (c == 2 || c == 3) begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++; $display("FAIL stall_in_ready[%0d]: got %b exp 0", c, in_ready);
                end
            end
            if (c == 4) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++; $display("FAIL simul_in_ready: got %b exp 1", in_ready);
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            if (c >= 1 && c <= 3) begin
                tests++;
                if (out_valid !== 1'b1 || {out_parity, out_ones, out_zero, out_y} !== r0) begin
                    fails++;
                    $display("FAIL stall_hold[%0d]: got v%b y=%h exp v1 y=%h", c, out_valid, out_y, r0[W-1:0]);
                end
            end
            if (c == 4) begin
                tests++;
                if (out_valid !== 1'b1 || out_y !== r1[W-1:0]) begin
                    fails++;
                    $display("FAIL simul_shift: got v%b y=%h exp v1 y=%h", out_valid, out_y, r1[W-1:0]);
                end
            end
        end
        in_valid = 1'b0;
        tests++;
        if (exp_cnt !== base + 16'd6 || done_cnt !== base + 16'd6 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL stall_count: got %0d (model %0d, pending %0d) exp %0d",
                     done_cnt, exp_cnt, exp_q.size(), base + 16'd6);
        end
    endtask

    task automatic test_random;
        logic acc;
        acc = 1'b1;
        for (int c = 0; c < 300; c++) begin
            // Payload changes only after the previous offer was taken.
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_op = 3'($urandom_range(0, 7));
                in_a = W'($urandom); in_b = W'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        tests++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL random_drain: got pending %0d v%b exp pending 0 v0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'd2; in_a = 8'h12; in_b = 8'h34;
        @(posedge clk); #1;
        in_op = 3'd1; in_a = 8'h56; in_b = 8'h78;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        exp_cnt = '0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_y !== '0 || out_zero !== 1'b0 || out_ones !== 1'b0 ||
            out_parity !== 1'b0 || done_cnt !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: got v%b y=%h z%b o%b p%b cnt%0d rdy%b exp v0 y=00 z0 o0 p0 cnt0 rdy1",
                     out_valid, out_y, out_zero, out_ones, out_parity, done_cnt, in_ready);
        end
        @(negedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        send_one(3'd0, 8'hFF, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0, "post_reset_and");
    endtask

    task automatic test_cnt_wrap;
        logic [1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            logic [EW-1:0] r;
            logic [2:0] op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
            r = ref_result(op, a, b);
            send_one(op, a, b, r[W-1:0], r[W], r[W+1], r[W+2], $sformatf("wrap_txn%0d", k));
            tests++;
            if (done_cnt2 !== seq[k]) begin
                fails++; $display("FAIL cnt_wrap[%0d]: got %0d exp %0d", k, done_cnt2, seq[k]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ops();
        test_flags();
        test_back_to_back();
        test_stall();
        test_random();
        test_async_reset();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Overall time bound so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion exp finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
